// File: rtl/unified_mem_responder.sv
// unified_mem_responder
// Word-addressed unified instruction/data memory that answers the memory port
// of the multicycle RISC-V core. It latches a request, waits a fixed number
// of cycles, commits writes, returns read data, and flags misaligned or
// out-of-range accesses.
//
// Parameters:
//   DEPTH     - number of 32-bit words (power of two, 4..1024)
//   LATENCY   - wait cycles inserted before the response (0..15)
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - asynchronous active-low reset
//   MemReq    - request valid (sampled in IDLE only)
//   MemWrite  - 1 = write, 0 = read, qualified by MemReq
//   Adr       - byte address
//   WriteData - store data
//   ReadData  - load data, registered, held until the next response
//   MemReady  - one-cycle response strobe
//   MemErr    - error flag, meaningful only while MemReady = 1

module unified_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Counter reload value; unused when LATENCY = 0.
  localparam logic [3:0] WAIT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] adr_reg;
  logic        write_reg;
  logic [31:0] wdata_reg;
  logic [31:0] read_data_reg;
  logic        err_reg;

  logic [31:0] mem_array [DEPTH];

  // With LATENCY = 0 the access happens on the accepting edge itself, before
  // the latches hold the request, so the live inputs are used in IDLE.
  logic          use_live;
  logic [31:0]   req_adr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic [AW-1:0] req_idx;
  logic          req_err;
  logic          accept;
  logic          enter_resp;

  assign use_live  = (state_reg == ST_IDLE);
  assign req_adr   = use_live ? Adr       : adr_reg;
  assign req_write = use_live ? MemWrite  : write_reg;
  assign req_wdata = use_live ? WriteData : wdata_reg;
  assign req_idx   = req_adr[AW+1:2];
  assign req_err   = (|req_adr[1:0]) | (|req_adr[31:AW+2]);

  assign accept     = (state_reg == ST_IDLE) && MemReq;
  assign enter_resp = (accept && (LATENCY == 0)) ||
                      ((state_reg == ST_WAIT) && (cnt_reg == 4'd0));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (MemReq) begin
          if (LATENCY == 0) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        // MemReq is deliberately not sampled here: one IDLE cycle always
        // separates consecutive transactions.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      adr_reg       <= 32'd0;
      write_reg     <= 1'b0;
      wdata_reg     <= 32'd0;
      read_data_reg <= 32'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        adr_reg   <= Adr;
        write_reg <= MemWrite;
        wdata_reg <= WriteData;
      end
      if (enter_resp) begin
        err_reg <= req_err;
        if (req_err) begin
          read_data_reg <= 32'd0;
        end else if (req_write) begin
          read_data_reg <= req_wdata;
        end else begin
          read_data_reg <= mem_array[req_idx];
        end
      end
    end
  end

  // Storage is never reset. A write commits only on the edge entering RESP,
  // so a reset during WAIT drops it while an already-committed write stays.
  always_ff @(posedge clk) begin
    if (enter_resp && req_write && !req_err) begin
      mem_array[req_idx] <= req_wdata;
    end
  end

  assign ReadData = read_data_reg;
  assign MemReady = (state_reg == ST_RESP);
  assign MemErr   = (state_reg == ST_RESP) && err_reg;

endmodule
